// File: rtl/eth_l2_pkg.sv
// eth_l2_pkg: shared L2 header constants, decoder state and metadata record, plus the field decode.
package eth_l2_pkg;
  localparam logic [15:0] TPID_8021Q       = 16'h8100;
  localparam logic [15:0] TPID_8021AD      = 16'h88A8;
  localparam logic [15:0] TPID_QINQ_LEGACY = 16'h9100;
  localparam logic [15:0] ETHERTYPE_MIN    = 16'h0600;
  localparam logic [4:0]  L2_LEN_UNTAGGED  = 5'd14;
  localparam logic [4:0]  L2_LEN_TAGGED    = 5'd18;
  typedef enum logic [1:0] {IDLE, DECODE, HOLD} l2dec_state_e;
  typedef struct packed {
    logic [47:0] dst_mac;
    logic [47:0] src_mac;
    logic        vlan_present;
    logic [15:0] vlan_tci;
    logic [15:0] ethertype;
    logic        is_length;
    logic        stacked_tag;
    logic [4:0]  l2_hdr_len;
    logic        is_broadcast;
    logic        is_multicast;
  } l2_meta_t;
  // Wire byte i sits at [i*8 +: 8]; byte 0 is the most significant octet of every field.
  function automatic l2_meta_t l2_decode(input logic [143:0] h);
    l2_meta_t m;
    logic [15:0] tpid;
    tpid = {h[96 +: 8], h[104 +: 8]};
    m.dst_mac = {h[0 +: 8], h[8 +: 8], h[16 +: 8], h[24 +: 8], h[32 +: 8], h[40 +: 8]};
    m.src_mac = {h[48 +: 8], h[56 +: 8], h[64 +: 8], h[72 +: 8], h[80 +: 8], h[88 +: 8]};
    m.vlan_present = tpid == TPID_8021Q;
    m.stacked_tag = tpid == TPID_8021AD || tpid == TPID_QINQ_LEGACY;
    m.vlan_tci = m.vlan_present ? {h[112 +: 8], h[120 +: 8]} : 16'h0;
    m.ethertype = m.vlan_present ? {h[128 +: 8], h[136 +: 8]} : tpid;
    m.is_length = m.ethertype < ETHERTYPE_MIN;
    m.l2_hdr_len = m.vlan_present ? L2_LEN_TAGGED : L2_LEN_UNTAGGED;
    m.is_broadcast = &m.dst_mac;
    m.is_multicast = h[0] & ~m.is_broadcast;
    return m;
  endfunction
endpackage

// File: rtl/l2_header_decoder.sv
// l2_header_decoder: decodes a captured L2 header into one registered metadata record per frame.
module l2_header_decoder
  import eth_l2_pkg::*;
#(
  parameter int L2_HEADER_MAX_BYTES = 18,
  parameter int DROP_CNT_WIDTH      = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             frame_start,
  input  logic [L2_HEADER_MAX_BYTES*8-1:0] header_bytes,
  input  logic                             header_valid,
  output logic [47:0]                      dst_mac,
  output logic [47:0]                      src_mac,
  output logic                             vlan_present,
  output logic [15:0]                      vlan_tci,
  output logic [15:0]                      ethertype,
  output logic                             is_length,
  output logic                             stacked_tag,
  output logic [4:0]                       l2_hdr_len,
  output logic                             is_broadcast,
  output logic                             is_multicast,
  output logic                             meta_valid,
  input  logic                             meta_ready,
  output logic [DROP_CNT_WIDTH-1:0]        drop_count
);
  l2dec_state_e state, state_nxt;
  logic hv_q, hdr_rise, latch, drop;
  logic [L2_HEADER_MAX_BYTES*8-1:0] hdr_r;
  l2_meta_t meta;
  if (L2_HEADER_MAX_BYTES < 18) begin : g_bad_size
    $error("L2_HEADER_MAX_BYTES must be at least 18");
  end
  assign hdr_rise = header_valid & ~hv_q;
  always_comb begin
    state_nxt = state;
    latch = 1'b0;
    drop = 1'b0;
    case (state)
      IDLE: begin
        latch = hdr_rise;
        state_nxt = hdr_rise ? DECODE : IDLE;
      end
      DECODE: begin
        drop = hdr_rise;
        state_nxt = HOLD;
      end
      HOLD: begin
        latch = hdr_rise & meta_ready;
        drop = hdr_rise & ~meta_ready;
        state_nxt = meta_ready ? (hdr_rise ? DECODE : IDLE) : HOLD;
      end
      default: state_nxt = IDLE;
    endcase
  end
  // frame_start clears the edge detector so the next header_valid high is seen as fresh.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      hv_q <= 1'b0;
      hdr_r <= '0;
      meta <= '0;
      drop_count <= '0;
    end else begin
      state <= state_nxt;
      hv_q <= header_valid & ~frame_start;
      if (latch) hdr_r <= header_bytes;
      if (state == DECODE) meta <= l2_decode(hdr_r[143:0]);
      if (drop && !(&drop_count)) drop_count <= drop_count + DROP_CNT_WIDTH'(1);
    end
  end
  assign meta_valid   = state == HOLD;
  assign dst_mac      = meta.dst_mac;
  assign src_mac      = meta.src_mac;
  assign vlan_present = meta.vlan_present;
  assign vlan_tci     = meta.vlan_tci;
  assign ethertype    = meta.ethertype;
  assign is_length    = meta.is_length;
  assign stacked_tag  = meta.stacked_tag;
  assign l2_hdr_len   = meta.l2_hdr_len;
  assign is_broadcast = meta.is_broadcast;
  assign is_multicast = meta.is_multicast;
endmodule

// File: tb/tb_l2_header_decoder.sv
// tb_l2_header_decoder: table vectors, handshake corner sequences and random traffic against a transaction model.
module tb_l2_header_decoder;
  localparam int NB = 18;
  localparam int DW = 16;
  logic clk = 1'b0, rst_n = 1'b0, frame_start = 1'b0, header_valid = 1'b0, meta_ready = 1'b0;
  logic [NB*8-1:0] header_bytes = '0;
  logic [47:0] dst_mac, src_mac;
  logic vlan_present, is_length, stacked_tag, is_broadcast, is_multicast, meta_valid;
  logic [15:0] vlan_tci, ethertype;
  logic [4:0] l2_hdr_len;
  logic [DW-1:0] drop_count;

  l2_header_decoder #(.L2_HEADER_MAX_BYTES(NB), .DROP_CNT_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .header_bytes(header_bytes),
    .header_valid(header_valid), .dst_mac(dst_mac), .src_mac(src_mac),
    .vlan_present(vlan_present), .vlan_tci(vlan_tci), .ethertype(ethertype),
    .is_length(is_length), .stacked_tag(stacked_tag), .l2_hdr_len(l2_hdr_len),
    .is_broadcast(is_broadcast), .is_multicast(is_multicast), .meta_valid(meta_valid),
    .meta_ready(meta_ready), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  typedef logic [7:0] hdr_t [NB];
  typedef struct packed {
    logic [47:0] dst;
    logic [47:0] src;
    logic        vlan;
    logic [15:0] tci;
    logic [15:0] et;
    logic        islen;
    logic        stk;
    logic [4:0]  len;
    logic        bc;
    logic        mc;
  } meta_t;
  typedef struct packed {
    logic        vlan;
    logic [15:0] tci;
    logic [15:0] et;
    logic        islen;
    logic        stk;
    logic [4:0]  len;
    logic        bc;
    logic        mc;
  } flags_t;
  typedef struct packed {
    logic [47:0] dst;
    logic [47:0] src;
    logic [15:0] tpid;
    logic [15:0] w14;
    logic [15:0] w16;
    flags_t      exp;
  } vec_t;

  int n_chk = 0, n_fail = 0;
  hdr_t cur;
  logic m_hvq;
  bit m_pend, m_valid;
  hdr_t m_hdr;
  meta_t m_meta;
  int m_drops;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic meta_t ref_decode(input hdr_t b);
    meta_t m;
    logic [15:0] tpid;
    m.dst = 0;
    m.src = 0;
    for (int i = 0; i < 6; i++) begin
      m.dst = (m.dst << 8) | 48'(b[i]);
      m.src = (m.src << 8) | 48'(b[6+i]);
    end
    tpid = {b[12], b[13]};
    m.vlan = tpid == 16'h8100;
    m.stk = tpid == 16'h88A8 || tpid == 16'h9100;
    m.tci = m.vlan ? {b[14], b[15]} : 16'h0;
    m.et = m.vlan ? {b[16], b[17]} : tpid;
    m.islen = m.et < 16'd1536;
    m.len = m.vlan ? 5'd18 : 5'd14;
    m.bc = m.dst == 48'hFFFF_FFFF_FFFF;
    m.mc = b[0][0] && !m.bc;
    return m;
  endfunction

  function automatic hdr_t mk_hdr(input logic [47:0] d, input logic [47:0] s,
                                  input logic [15:0] t, input logic [15:0] w14, input logic [15:0] w16);
    hdr_t h;
    for (int i = 0; i < 6; i++) begin
      h[i] = d[47-8*i -: 8];
      h[6+i] = s[47-8*i -: 8];
    end
    h[12] = t[15:8];  h[13] = t[7:0];
    h[14] = w14[15:8]; h[15] = w14[7:0];
    h[16] = w16[15:8]; h[17] = w16[7:0];
    return h;
  endfunction

  function automatic hdr_t rand_hdr();
    logic [47:0] d;
    logic [15:0] t;
    int sel;
    sel = $urandom_range(0, 5);
    t = sel == 0 ? 16'h8100 : sel == 1 ? 16'h88A8 : sel == 2 ? 16'h9100 :
        sel == 3 ? 16'($urandom_range(0, 16'h05FF)) : 16'($urandom);
    d = {16'($urandom), 32'($urandom)};
    sel = $urandom_range(0, 3);
    if (sel == 0) d = '1;
    else if (sel == 1) d[40] = 1'b1;
    return mk_hdr(d, {16'($urandom), 32'($urandom)}, t, 16'($urandom), 16'($urandom));
  endfunction

  task automatic set_hdr(input hdr_t h);
    cur = h;
    for (int i = 0; i < NB; i++) header_bytes[i*8 +: 8] = h[i];
  endtask

  function automatic meta_t dut_rec();
    return {dst_mac, src_mac, vlan_present, vlan_tci, ethertype, is_length, stacked_tag,
            l2_hdr_len, is_broadcast, is_multicast};
  endfunction

  task automatic model_reset();
    m_hvq = 1'b0; m_pend = 0; m_valid = 0; m_meta = '0; m_drops = 0;
  endtask

  // One clock: model predicts the edge from the inputs currently applied, then DUT is compared 1 time unit later.
  task automatic tick(input bit do_chk);
    bit rise, taken, busy;
    rise = header_valid && !m_hvq;
    taken = m_valid && meta_ready;
    busy = m_pend || (m_valid && !taken);
    @(posedge clk);
    #1;
    if (m_pend) begin
      m_meta = ref_decode(m_hdr);
      m_valid = 1;
    end else if (taken) m_valid = 0;
    m_pend = rise && !busy;
    if (m_pend) m_hdr = cur;
    if (rise && busy && m_drops < 65535) m_drops++;
    m_hvq = header_valid && !frame_start;
    if (do_chk) begin
      chk("meta_valid", 160'(meta_valid), 160'(m_valid));
      chk("drop_count", 160'(drop_count), 160'(m_drops));
      chk("record", 160'(dut_rec()), 160'(m_meta));
    end
  endtask

  task automatic send(input hdr_t h, input bit rdy);
    frame_start = 1'b1; header_valid = 1'b0; meta_ready = rdy;
    tick(1);
    frame_start = 1'b0; header_valid = 1'b1; set_hdr(h);
    tick(1);
  endtask

  localparam int NV = 9;
  vec_t vecs [NV];
  hdr_t ha, hb, hc;

  initial begin
    vecs[0] = '{48'h001122334455, 48'h66778899AABB, 16'h0800, 16'h0000, 16'h0000,
                '{1'b0, 16'h0000, 16'h0800, 1'b0, 1'b0, 5'd14, 1'b0, 1'b0}};
    vecs[1] = '{48'h001122334455, 48'h66778899AABB, 16'h8100, 16'h6064, 16'h86DD,
                '{1'b1, 16'h6064, 16'h86DD, 1'b0, 1'b0, 5'd18, 1'b0, 1'b0}};
    vecs[2] = '{48'hFFFFFFFFFFFF, 48'h66778899AABB, 16'h0026, 16'hABCD, 16'h1234,
                '{1'b0, 16'h0000, 16'h0026, 1'b1, 1'b0, 5'd14, 1'b1, 1'b0}};
    vecs[3] = '{48'h01005E000001, 48'h66778899AABB, 16'h0800, 16'h0000, 16'h0000,
                '{1'b0, 16'h0000, 16'h0800, 1'b0, 1'b0, 5'd14, 1'b0, 1'b1}};
    vecs[4] = '{48'h001122334455, 48'h66778899AABB, 16'h88A8, 16'h0064, 16'h0800,
                '{1'b0, 16'h0000, 16'h88A8, 1'b0, 1'b1, 5'd14, 1'b0, 1'b0}};
    vecs[5] = '{48'h001122334455, 48'h66778899AABB, 16'h9100, 16'h0001, 16'h86DD,
                '{1'b0, 16'h0000, 16'h9100, 1'b0, 1'b1, 5'd14, 1'b0, 1'b0}};
    vecs[6] = '{48'h020000000001, 48'h0A0B0C0D0E0F, 16'h05FF, 16'h0000, 16'h0000,
                '{1'b0, 16'h0000, 16'h05FF, 1'b1, 1'b0, 5'd14, 1'b0, 1'b0}};
    vecs[7] = '{48'h020000000001, 48'h0A0B0C0D0E0F, 16'h0600, 16'h0000, 16'h0000,
                '{1'b0, 16'h0000, 16'h0600, 1'b0, 1'b0, 5'd14, 1'b0, 1'b0}};
    vecs[8] = '{48'h333300000001, 48'h0A0B0C0D0E0F, 16'h8100, 16'hE00A, 16'h0040,
                '{1'b1, 16'hE00A, 16'h0040, 1'b1, 1'b0, 5'd18, 1'b0, 1'b1}};
    model_reset();
    set_hdr(mk_hdr('0, '0, '0, '0, '0));
    #1;
    chk("reset_outputs", 160'(dut_rec()), 160'(0));
    chk("reset_valid", 160'(meta_valid), 160'(0));
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    tick(1);

    for (int k = 0; k < NV; k++) begin
      send(mk_hdr(vecs[k].dst, vecs[k].src, vecs[k].tpid, vecs[k].w14, vecs[k].w16), 1'b1);
      tick(1);
      chk($sformatf("tbl%0d_valid", k), 160'(meta_valid), 160'(1));
      chk($sformatf("tbl%0d_dst", k), 160'(dst_mac), 160'(vecs[k].dst));
      chk($sformatf("tbl%0d_src", k), 160'(src_mac), 160'(vecs[k].src));
      chk($sformatf("tbl%0d_flags", k),
          160'({vlan_present, vlan_tci, ethertype, is_length, stacked_tag, l2_hdr_len, is_broadcast, is_multicast}),
          160'(vecs[k].exp));
      tick(1);
      chk($sformatf("tbl%0d_oneshot", k), 160'(meta_valid), 160'(0));
    end

    ha = mk_hdr(48'h00AA00AA00AA, 48'h001100110011, 16'h0800, 16'h0, 16'h0);
    hb = mk_hdr(48'h00BB00BB00BB, 48'h002200220022, 16'h86DD, 16'h0, 16'h0);
    hc = mk_hdr(48'h00CC00CC00CC, 48'h003300330033, 16'h8100, 16'h0123, 16'h0806);
    send(ha, 1'b0);
    tick(1);
    chk("bp_first_valid", 160'(meta_valid), 160'(1));
    send(hb, 1'b0);
    tick(1);
    chk("bp_drop_count", 160'(drop_count), 160'(1));
    chk("bp_first_kept", 160'(dst_mac), 160'(48'h00AA00AA00AA));
    chk("bp_still_valid", 160'(meta_valid), 160'(1));
    frame_start = 1'b1; header_valid = 1'b0;
    tick(1);
    frame_start = 1'b0; header_valid = 1'b1; set_hdr(hc); meta_ready = 1'b1;
    tick(1);
    chk("sc_gap", 160'(meta_valid), 160'(0));
    meta_ready = 1'b0;
    tick(1);
    chk("sc_valid", 160'(meta_valid), 160'(1));
    chk("sc_dst", 160'(dst_mac), 160'(48'h00CC00CC00CC));
    chk("sc_no_drop", 160'(drop_count), 160'(1));
    meta_ready = 1'b1;
    tick(1);

    for (int n = 0; n < 800; n++) begin
      frame_start = $urandom_range(0, 3) == 0;
      header_valid = frame_start ? 1'b0 : $urandom_range(0, 3) != 0;
      meta_ready = $urandom_range(0, 2) != 0;
      set_hdr(rand_hdr());
      tick(1);
    end

    meta_ready = 1'b0; frame_start = 1'b1; header_valid = 1'b1;
    repeat (65545) tick(0);
    tick(1);
    chk("sat_drop_count", 160'(drop_count), 160'(16'hFFFF));
    tick(1);
    chk("sat_hold", 160'(drop_count), 160'(16'hFFFF));
    chk("sat_pending", 160'(meta_valid), 160'(1));

    frame_start = 1'b0; set_hdr(ha);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_mid_outputs", 160'(dut_rec()), 160'(0));
    chk("rst_mid_valid", 160'(meta_valid), 160'(0));
    chk("rst_mid_drops", 160'(drop_count), 160'(0));
    @(negedge clk) rst_n = 1'b1;
    tick(1);
    tick(1);
    chk("post_rst_valid", 160'(meta_valid), 160'(1));
    chk("post_rst_dst", 160'(dst_mac), 160'(48'h00AA00AA00AA));
    meta_ready = 1'b1;
    tick(1);
    tick(1);
    chk("post_rst_single", 160'(meta_valid), 160'(0));
    chk("post_rst_drops", 160'(drop_count), 160'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/l2_header_decoder.md
# l2_header_decoder

Decodes the captured Ethernet L2 header buffer into MAC addresses, an optional 802.1Q tag, the EtherType/length and address-class flags. It sits directly downstream of the L2 header capture stage and consumes its `header_bytes`/`header_valid` pair. It presents one registered metadata record per frame on a valid/ready handshake toward the L3 dispatch logic. Headers that arrive while a record is still pending are dropped and counted.

## Interface
- `L2_HEADER_MAX_BYTES`, 18, capture buffer size in bytes; must be ≥ 18, enforced by an elaboration-time check.
- `DROP_CNT_WIDTH`, 16, width of the drop counter.

- `clk`  in  1  clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `frame_start`  in  1  one-cycle pulse marking the start of a new frame.
- `header_bytes`  in  L2_HEADER_MAX_BYTES*8  header buffer; wire byte i is at `[i*8 +: 8]`.
- `header_valid`  in  1  level signal; high once the buffer is full, low again after `frame_start`.
- `dst_mac`  out  48  destination MAC = {byte0..byte5}, with byte0 as the MSB.
- `src_mac`  out  48  source MAC = {byte6..byte11}.
- `vlan_present`  out  1  outer TPID == 0x8100.
- `vlan_tci`  out  16  {byte14, byte15} when `vlan_present`, else 0.
- `ethertype`  out  16  {byte12, byte13}, or {byte16, byte17} when `vlan_present`.
- `is_length`  out  1  `ethertype` < 0x0600, i.e. an 802.3 length field.
- `stacked_tag`  out  1  outer TPID is 0x88A8 or 0x9100 (unsupported); `ethertype` is then the raw {byte12, byte13}.
- `l2_hdr_len`  out  5  18 if `vlan_present`, else 14.
- `is_broadcast`  out  1  `dst_mac` == 48'hFFFF_FFFF_FFFF.
- `is_multicast`  out  1  bit 0 of byte0 is set and the frame is not broadcast.
- `meta_valid`  out  1  metadata record valid.
- `meta_ready`  in  1  consumer accepts the record.
- `drop_count`  out  DROP_CNT_WIDTH  saturating count of dropped headers.

## Operation
- `hv_q` is a registered copy of `header_valid`. `hdr_rise = header_valid & ~hv_q`.
- FSM states:
  - IDLE: on `hdr_rise`, latch `header_bytes` into `hdr_r` and go to DECODE.
  - DECODE: compute all fields from `hdr_r`, register them into the output registers, set `meta_valid`, and go to HOLD.
  - HOLD: `meta_valid` = 1 and the outputs are stable.
    - On `meta_ready`, clear `meta_valid` and go to IDLE.
    - If `hdr_rise` occurs in the same cycle as `meta_ready`, latch the new header and go to DECODE. This is not a drop.
- A `hdr_rise` seen in DECODE, or in HOLD without `meta_ready`, is a drop: the header is discarded and `drop_count` increments. `drop_count` saturates at all-ones.
- `frame_start` does not cancel a pending record. The record belongs to the previous frame and is still delivered. `frame_start` only lets `hv_q` see a fresh rising edge.
- Outputs change only on the DECODE→HOLD transition. They hold their last values while in IDLE.
- All field comparisons are unsigned. `l2_hdr_len` is a constant 14 or 18 selected by `vlan_present`.

## Timing
- Reset (asynchronous): state = IDLE, `hv_q` = 0, `hdr_r` = 0, all metadata outputs = 0, `meta_valid` = 0, `drop_count` = 0.
- Latency: `header_valid` first sampled high at edge N → `hdr_r` latched at N → fields registered and `meta_valid` = 1 after edge N+1.
- Throughput: one record every 2 cycles when `meta_ready` is held high.
- Handshake: a transfer occurs on a clock edge where `meta_valid` & `meta_ready`. Outputs must not change while `meta_valid` = 1 and `meta_ready` = 0.
- `header_valid` already high on release of reset: `hv_q` = 0, so this counts as a rising edge and is decoded.
- Reset asserted mid-operation: the pending record is lost and there is no drop increment.

## Structure
- Package `eth_l2_pkg` holds:
  - constants `TPID_8021Q` = 16'h8100, `TPID_8021AD` = 16'h88A8, `TPID_QINQ_LEGACY` = 16'h9100, `ETHERTYPE_MIN` = 16'h0600, `L2_LEN_UNTAGGED` = 14, `L2_LEN_TAGGED` = 18;
  - enum `l2dec_state_e` {IDLE, DECODE, HOLD};
  - packed struct `l2_meta_t` holding all metadata fields.
- Single module with no sub-module. The decode is combinational on `hdr_r`, registered into an `l2_meta_t`.

## Test plan
- Untagged IPv4 frame, dst 00:11:22:33:44:55, src 66:77:88:99:AA:BB, type 0x0800, `meta_ready` = 1 → after 2 cycles: `ethertype` = 0x0800, `l2_hdr_len` = 14, `vlan_present` = 0, `is_multicast` = 0, one-cycle `meta_valid`.
- Tagged frame, TPID 0x8100, TCI 0x6064, inner type 0x86DD → `vlan_present` = 1, `vlan_tci` = 0x6064, `ethertype` = 0x86DD, `l2_hdr_len` = 18.
- dst FF:FF:FF:FF:FF:FF with type 0x0026 → `is_broadcast` = 1, `is_multicast` = 0, `is_length` = 1. Then dst 01:00:5E:00:00:01 → `is_multicast` = 1.
- TPID 0x88A8 → `stacked_tag` = 1, `vlan_present` = 0, `ethertype` = 0x88A8.
- Backpressure:
  - `meta_ready` = 0, second header arrives while in HOLD → `drop_count` = 1 and the first record is unchanged.
  - Second header arriving in the same cycle `meta_ready` = 1 → no drop, and the second record is valid 2 cycles later.
  - Force 65 540 drops → `drop_count` saturates at 16'hFFFF.
- Assert `rst_n` while in HOLD → `meta_valid` = 0 and all outputs = 0 immediately. After release with `header_valid` held high, one record is decoded.
